// File: rtl/rect_hit_scanner.sv
// rect_hit_scanner: raster-tracking multi-rectangle hit tester, 2-stage pipelined, frame-synchronous config commit
// Ports:
//   clock, resetn          system clock, asynchronous active-low reset
//   pix_valid, frame_start one active pixel this cycle; frame_start marks pixel (0,0)
//   cfg_wr, cfg_idx, cfg_*  shadow rectangle write (enable, x, y, width, height)
//   hit_valid, hit, hit_mask, hit_id, px_x, px_y  result for the pixel issued 2 cycles earlier
//   commit                 one-cycle pulse when shadow config was copied to active
// Optional (`define COLLISION_LATCH_EN): coll_clr in, coll_flags out (sticky multi-hit flags)
module rect_hit_scanner #(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int NUM_RECT = 4,
  parameter int IDX_W    = 2,
  parameter int COORD_W  = 10
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                pix_valid,
  input  logic                frame_start,
  input  logic                cfg_wr,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic                cfg_en,
  input  logic [COORD_W-1:0]  cfg_x,
  input  logic [COORD_W-1:0]  cfg_y,
  input  logic [COORD_W-1:0]  cfg_w,
  input  logic [COORD_W-1:0]  cfg_h,
`ifdef COLLISION_LATCH_EN
  input  logic                coll_clr,
  output logic [NUM_RECT-1:0] coll_flags,
`endif
  output logic                hit_valid,
  output logic                hit,
  output logic [NUM_RECT-1:0] hit_mask,
  output logic [IDX_W-1:0]    hit_id,
  output logic [COORD_W-1:0]  px_x,
  output logic [COORD_W-1:0]  px_y,
  output logic                commit
);
  logic [NUM_RECT-1:0] sh_en, ac_en, ef_en;
  logic [COORD_W-1:0]  sh_x [NUM_RECT];
  logic [COORD_W-1:0]  sh_y [NUM_RECT];
  logic [COORD_W-1:0]  sh_w [NUM_RECT];
  logic [COORD_W-1:0]  sh_h [NUM_RECT];
  logic [COORD_W-1:0]  ac_x [NUM_RECT];
  logic [COORD_W-1:0]  ac_y [NUM_RECT];
  logic [COORD_W-1:0]  ac_w [NUM_RECT];
  logic [COORD_W-1:0]  ac_h [NUM_RECT];
  logic [COORD_W-1:0]  ef_x [NUM_RECT];
  logic [COORD_W-1:0]  ef_y [NUM_RECT];
  logic [COORD_W-1:0]  ef_w [NUM_RECT];
  logic [COORD_W-1:0]  ef_h [NUM_RECT];
  logic [COORD_W-1:0]  nx, ny, cx, cy;
  logic                do_commit;
  logic [NUM_RECT-1:0] mask_c;
  logic                s1_v;
  logic [NUM_RECT-1:0] s1_m;
  logic [COORD_W-1:0]  s1_x, s1_y;
  logic [IDX_W-1:0]    id_c;
  assign do_commit = pix_valid && frame_start;
  // nx/ny hold the coordinate the next pixel takes unless it restarts the frame
  assign cx = frame_start ? '0 : nx;
  assign cy = frame_start ? '0 : ny;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      nx <= '0;
      ny <= '0;
    end else if (pix_valid) begin
      nx <= (cx == COORD_W'(H_RES - 1)) ? '0 : cx + 1'b1;
      ny <= (cx == COORD_W'(H_RES - 1)) ? ((cy == COORD_W'(V_RES - 1)) ? '0 : cy + 1'b1) : cy;
    end
  // the frame-start pixel already sees the set being committed on that edge
  always_comb begin
    ef_en = do_commit ? sh_en : ac_en;
    for (int i = 0; i < NUM_RECT; i++) begin
      ef_x[i] = do_commit ? sh_x[i] : ac_x[i];
      ef_y[i] = do_commit ? sh_y[i] : ac_y[i];
      ef_w[i] = do_commit ? sh_w[i] : ac_w[i];
      ef_h[i] = do_commit ? sh_h[i] : ac_h[i];
    end
  end
  // far edges are formed one bit wider so x0+w never wraps back on screen
  always_comb begin
    mask_c = '0;
    for (int i = 0; i < NUM_RECT; i++)
      mask_c[i] = ef_en[i] && cx >= ef_x[i] && {1'b0, cx} < {1'b0, ef_x[i]} + {1'b0, ef_w[i]}
                  && cy >= ef_y[i] && {1'b0, cy} < {1'b0, ef_y[i]} + {1'b0, ef_h[i]};
  end
  // shadow write lands after the copy, so a write on the commit beat waits a frame
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      sh_en <= '0;
      ac_en <= '0;
      for (int i = 0; i < NUM_RECT; i++) begin
        sh_x[i] <= '0;
        sh_y[i] <= '0;
        sh_w[i] <= '0;
        sh_h[i] <= '0;
        ac_x[i] <= '0;
        ac_y[i] <= '0;
        ac_w[i] <= '0;
        ac_h[i] <= '0;
      end
    end else begin
      if (do_commit) begin
        ac_en <= sh_en;
        for (int i = 0; i < NUM_RECT; i++) begin
          ac_x[i] <= sh_x[i];
          ac_y[i] <= sh_y[i];
          ac_w[i] <= sh_w[i];
          ac_h[i] <= sh_h[i];
        end
      end
      if (cfg_wr && 32'(cfg_idx) < NUM_RECT) begin
        sh_en[cfg_idx] <= cfg_en;
        sh_x[cfg_idx]  <= cfg_x;
        sh_y[cfg_idx]  <= cfg_y;
        sh_w[cfg_idx]  <= cfg_w;
        sh_h[cfg_idx]  <= cfg_h;
      end
    end
  always_comb begin
    id_c = '0;
    for (int i = NUM_RECT - 1; i >= 0; i--)
      if (s1_m[i]) id_c = IDX_W'(i);
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      s1_v      <= 1'b0;
      s1_m      <= '0;
      s1_x      <= '0;
      s1_y      <= '0;
      hit_valid <= 1'b0;
      hit       <= 1'b0;
      hit_mask  <= '0;
      hit_id    <= '0;
      px_x      <= '0;
      px_y      <= '0;
      commit    <= 1'b0;
    end else begin
      s1_v      <= pix_valid;
      hit_valid <= s1_v;
      commit    <= do_commit;
      if (pix_valid) begin
        s1_m <= mask_c;
        s1_x <= cx;
        s1_y <= cy;
      end
      if (s1_v) begin
        hit_mask <= s1_m;
        hit      <= |s1_m;
        hit_id   <= id_c;
        px_x     <= s1_x;
        px_y     <= s1_y;
      end
    end
`ifdef COLLISION_LATCH_EN
  // m & (m-1) is nonzero exactly when two or more rectangles hit
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) coll_flags <= '0;
    else if (coll_clr) coll_flags <= '0;
    else if (s1_v && |(s1_m & (s1_m - 1'b1))) coll_flags <= coll_flags | s1_m;
`endif
endmodule

// File: tb/tb_rect_hit_scanner.sv
// tb_rect_hit_scanner: randomized frames checked every cycle against a behavioural raster/rectangle model
module tb_rect_hit_scanner;
  localparam int H = 640, V = 10, N = 4, IW = 2, CW = 10;
  logic clock = 0, resetn = 0, pix_valid = 0, frame_start = 0, cfg_wr = 0, cfg_en = 0;
  logic [IW-1:0] cfg_idx = '0;
  logic [CW-1:0] cfg_x = '0, cfg_y = '0, cfg_w = '0, cfg_h = '0;
  logic hit_valid, hit, commit;
  logic [N-1:0] hit_mask;
  logic [IW-1:0] hit_id;
  logic [CW-1:0] px_x, px_y;
`ifdef COLLISION_LATCH_EN
  logic coll_clr = 0;
  logic [N-1:0] coll_flags;
`endif
  always #5 clock = ~clock;
  rect_hit_scanner #(.H_RES(H), .V_RES(V), .NUM_RECT(N), .IDX_W(IW), .COORD_W(CW)) dut (
    .clock(clock), .resetn(resetn), .pix_valid(pix_valid), .frame_start(frame_start),
    .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .cfg_w(cfg_w), .cfg_h(cfg_h),
`ifdef COLLISION_LATCH_EN
    .coll_clr(coll_clr), .coll_flags(coll_flags),
`endif
    .hit_valid(hit_valid), .hit(hit), .hit_mask(hit_mask), .hit_id(hit_id),
    .px_x(px_x), .px_y(px_y), .commit(commit));
  typedef struct packed {bit v; int x; int y; bit [N-1:0] m;} item_t;
  item_t q[$];
  int sh_en[N], sh_x[N], sh_y[N], sh_w[N], sh_h[N];
  int ac_en[N], ac_x[N], ac_y[N], ac_w[N], ac_h[N];
  int nx, ny, vis_x, vis_y;
  bit vis_v, vis_commit;
  bit [N-1:0] vis_m, vis_coll;
  int checks = 0, errors = 0, phase = 0;
  int pw_idx, pw_en, pw_x, pw_y, pw_w, pw_h;
  task chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d expected %0d (phase %0d t=%0t)", nm, act, exp, phase, $time);
    end
  endtask
  task model_reset();
    for (int i = 0; i < N; i++) begin
      sh_en[i] = 0; sh_x[i] = 0; sh_y[i] = 0; sh_w[i] = 0; sh_h[i] = 0;
      ac_en[i] = 0; ac_x[i] = 0; ac_y[i] = 0; ac_w[i] = 0; ac_h[i] = 0;
    end
    nx = 0; ny = 0; vis_x = 0; vis_y = 0;
    vis_v = 0; vis_commit = 0; vis_m = '0; vis_coll = '0;
    q.delete();
    q.push_back('0);
  endtask
  function bit in_rect(int i, int x, int y);
    return ac_en[i] != 0 && x >= ac_x[i] && x < ac_x[i] + ac_w[i] && y >= ac_y[i] && y < ac_y[i] + ac_h[i];
  endfunction
  task model_edge();
    item_t p, it;
    p = q.pop_front();
    vis_v = p.v;
    if (p.v) begin vis_m = p.m; vis_x = p.x; vis_y = p.y; end
`ifdef COLLISION_LATCH_EN
    if (coll_clr) vis_coll = '0;
    else if (p.v && $countones(p.m) >= 2) vis_coll |= p.m;
`endif
    vis_commit = pix_valid && frame_start;
    it = '0;
    if (pix_valid) begin
      if (frame_start) begin
        nx = 0; ny = 0;
        for (int i = 0; i < N; i++) begin
          ac_en[i] = sh_en[i]; ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i]; ac_w[i] = sh_w[i]; ac_h[i] = sh_h[i];
        end
      end
      it.v = 1; it.x = nx; it.y = ny;
      for (int i = 0; i < N; i++) it.m[i] = in_rect(i, nx, ny);
      nx++;
      if (nx == H) begin nx = 0; ny++; if (ny == V) ny = 0; end
    end
    if (cfg_wr && cfg_idx < N) begin
      sh_en[cfg_idx] = cfg_en; sh_x[cfg_idx] = cfg_x; sh_y[cfg_idx] = cfg_y;
      sh_w[cfg_idx] = cfg_w; sh_h[cfg_idx] = cfg_h;
    end
    q.push_back(it);
  endtask
  task cyc();
    int eid;
    @(posedge clock);
    if (!resetn) model_reset(); else model_edge();
    #1;
    eid = 0;
    for (int i = N - 1; i >= 0; i--) if (vis_m[i]) eid = i;
    chk("hit_valid", hit_valid, vis_v);
    chk("hit_mask", hit_mask, vis_m);
    chk("hit", hit, |vis_m);
    chk("hit_id", hit_id, eid);
    chk("px_x", px_x, vis_x);
    chk("px_y", px_y, vis_y);
    chk("commit", commit, vis_commit);
`ifdef COLLISION_LATCH_EN
    chk("coll_flags", coll_flags, vis_coll);
    if (phase == 4 && coll_clr) chk("lit_coll_clr", coll_flags, 0);
`endif
    if (resetn && phase >= 2 && pix_valid && frame_start) chk("lit_commit", commit, 1);
    if (vis_v) begin
      if (phase == 1 && vis_x == H - 1 && vis_y == V - 1) begin
        chk("lit_last_y", px_y, V - 1); chk("lit_last_hit", hit, 0);
      end
      if (phase == 2 && vis_y == 5 && vis_x inside {9, 10, 12, 13}) chk("lit_r0_row5", hit, vis_x inside {10, 12});
      if (phase == 2 && vis_y == 6 && vis_x == 11) chk("lit_r0_row6", hit, 1);
      if (phase == 2 && vis_y == 7 && vis_x == 11) chk("lit_r0_row7", hit, 0);
      if (phase == 2 && vis_y == 6 && vis_x == 12) chk("lit_r0_id", hit_id, 0);
      if (phase == 3 && vis_x == 10 && vis_y == 5) begin chk("lit_ovl_mask", hit_mask, 3); chk("lit_ovl_id", hit_id, 0); end
      if (phase == 3 && vis_x == 0 && vis_y == 0) begin chk("lit_full_hit", hit, 1); chk("lit_full_id", hit_id, 1); end
      if (phase == 3 && vis_x == H - 1 && vis_y == V - 1) chk("lit_full_last", hit_id, 1);
      if (phase == 4 && vis_x == 100 && vis_y == 8) chk("lit_r2_pending", hit_mask[2], 0);
      if (phase == 5 && vis_x == 100 && vis_y == 8) begin chk("lit_r2_live", hit_mask[2], 1); chk("lit_r2_id", hit_id, 1); end
      if (phase == 6 && vis_y == 2 && vis_x inside {634, 635, 639}) chk("lit_r3_edge", hit_mask, vis_x == 634 ? 0 : 8);
      if (phase == 6 && vis_y == 3 && vis_x == 0) chk("lit_r3_nowrap", hit_mask, 0);
      if (phase == 6 && vis_y == 0 && vis_x == 0) chk("lit_w0", hit_mask, 0);
      if (phase == 6 && vis_y == 4 && vis_x inside {629, 630, 639}) chk("lit_wide", hit_mask, vis_x == 629 ? 0 : 2);
    end
  endtask
  task idle(int n);
    pix_valid = 0; frame_start = 0;
    repeat (n) cyc();
  endtask
  task wr(int idx, int en, int x, int y, int w, int h);
    cfg_idx = IW'(idx); cfg_en = en[0]; cfg_x = CW'(x); cfg_y = CW'(y); cfg_w = CW'(w); cfg_h = CW'(h);
    cfg_wr = 1;
    cyc();
    cfg_wr = 0;
  endtask
  task automatic frame(int pct, int wr_at);
    int cnt = 0;
    while (cnt < H * V) begin
      pix_valid = $urandom_range(99) < pct;
      frame_start = pix_valid ? (cnt == 0) : ($urandom_range(9) == 0);
      if (pix_valid && cnt == wr_at) begin
        cfg_idx = IW'(pw_idx); cfg_en = pw_en[0]; cfg_x = CW'(pw_x); cfg_y = CW'(pw_y);
        cfg_w = CW'(pw_w); cfg_h = CW'(pw_h); cfg_wr = 1;
      end else if (phase == 7 && ((pix_valid && cnt == 0) || $urandom_range(29) == 0)) begin
        cfg_idx = IW'($urandom_range(N - 1)); cfg_en = $urandom_range(3) != 0;
        cfg_x = CW'($urandom_range(700)); cfg_y = CW'($urandom_range(12));
        cfg_w = CW'($urandom_range(1023)); cfg_h = CW'($urandom_range(12));
        cfg_wr = 1;
      end
      cyc();
      if (pix_valid) cnt++;
      cfg_wr = 0;
`ifdef COLLISION_LATCH_EN
      coll_clr = (phase == 4 && q[$].v && q[$].x == 10 && q[$].y == 5) || (phase == 7 && $urandom_range(199) == 0);
`endif
    end
    pix_valid = 0; frame_start = 0;
`ifdef COLLISION_LATCH_EN
    coll_clr = 0;
`endif
  endtask
  initial begin
    model_reset();
    idle(3);
    resetn = 1;
    phase = 1;
    frame(85, -1);
    pix_valid = 1; frame_start = 0;
    repeat (3) cyc();
    idle(4);
    wr(0, 1, 10, 5, 3, 2);
    phase = 2;
    frame(90, -1);
    idle(4);
    wr(1, 1, 0, 0, 640, 480);
    phase = 3;
    frame(90, -1);
    idle(4);
`ifdef COLLISION_LATCH_EN
    chk("lit_coll_set", coll_flags, 3);
`endif
    pw_idx = 2; pw_en = 1; pw_x = 100; pw_y = 8; pw_w = 1; pw_h = 1;
    phase = 4;
    frame(90, 4 * H);
    idle(4);
    phase = 5;
    frame(90, -1);
    idle(4);
    wr(0, 1, 0, 0, 0, 5);
    wr(1, 1, 630, 4, 1000, 1);
    wr(3, 1, 635, 2, 20, 1);
    phase = 6;
    frame(90, -1);
    idle(4);
    phase = 7;
    frame(80, -1);
    frame(80, -1);
    idle(4);
    phase = 8;
    pix_valid = 1; frame_start = 1;
    cyc();
    frame_start = 0;
    repeat (500) cyc();
    #2 resetn = 0;
    #1;
    chk("async_rst_valid", hit_valid, 0);
    chk("async_rst_mask", hit_mask, 0);
    chk("async_rst_px", px_x, 0);
    model_reset();
    idle(2);
    resetn = 1;
    frame(90, -1);
    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
